// File: rtl/avalon_mm_pkg.sv
// Shared command payload for the Avalon-MM pipeline bridge.
// Widths here are the defaults; the bridge re-derives the struct from its own parameters.
package avalon_mm_pkg;

    localparam int AVMM_DWIDTH  = 32;
    localparam int AVMM_AWIDTH  = 2;
    localparam int AVMM_BEWIDTH = AVMM_DWIDTH / 8;

    typedef struct packed {
        logic [AVMM_AWIDTH-1:0]  addr;
        logic [AVMM_DWIDTH-1:0]  wdata;
        logic [AVMM_BEWIDTH-1:0] be;
        logic                    write;
        logic                    read;
    } avmm_cmd_t;

    function automatic int pend_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/avalon_mm_skid_buf.sv
// 2-entry skid buffer: main register drives the output, skid catches one extra beat.
// Latency 1 cycle; in_rdy_o is registered (low only while the skid entry is occupied).
module avalon_mm_skid_buf
    import avalon_mm_pkg::*;
#(
    parameter type T = avmm_cmd_t
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic in_vld_i,
    output logic in_rdy_o,
    input  T     in_dat_i,
    output logic out_vld_o,
    input  logic out_rdy_i,
    output T     out_dat_o
);

    T     main_q, main_d;
    T     skid_q, skid_d;
    logic main_vld_q, main_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic acc;
    logic pop;

    assign acc = in_vld_i & ~skid_vld_q;
    assign pop = main_vld_q & out_rdy_i;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (pop) begin
            // acc cannot coincide with an occupied skid, so no third slot is needed
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (acc) begin
                main_d = in_dat_i;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (acc) begin
            if (!main_vld_q) begin
                main_d     = in_dat_i;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = in_dat_i;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign in_rdy_o  = ~skid_vld_q;
    assign out_vld_o = main_vld_q;
    assign out_dat_o = main_q;

endmodule

// File: rtl/avalon_mm_pipe_bridge.sv
// Registered Avalon-MM bridge: skid-buffered command path, registered read response, read cap.
// Latency: command 1 cycle min, response exactly 1 cycle; s_waitrequest only while skid is full.
module avalon_mm_pipe_bridge
    import avalon_mm_pkg::*;
#(
    parameter int  DWIDTH      = AVMM_DWIDTH,
    parameter int  AWIDTH      = AVMM_AWIDTH,
    parameter int  MAX_PENDING = 4,
    localparam int BEWIDTH     = DWIDTH / 8,
    localparam int PW          = pend_width(MAX_PENDING)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [AWIDTH-1:0]  s_address,
    input  logic               s_write,
    input  logic [DWIDTH-1:0]  s_writedata,
    input  logic [BEWIDTH-1:0] s_byteenable,
    input  logic               s_read,
    output logic               s_waitrequest,
    output logic [DWIDTH-1:0]  s_readdata,
    output logic               s_readdatavalid,
    output logic [AWIDTH-1:0]  m_address,
    output logic               m_write,
    output logic [DWIDTH-1:0]  m_writedata,
    output logic [BEWIDTH-1:0] m_byteenable,
    output logic               m_read,
    input  logic               m_waitrequest,
    input  logic [DWIDTH-1:0]  m_readdata,
    input  logic               m_readdatavalid,
    output logic [PW-1:0]      pending_o,
    output logic               err_o
);

    typedef struct packed {
        logic [AWIDTH-1:0]  addr;
        logic [DWIDTH-1:0]  wdata;
        logic [BEWIDTH-1:0] be;
        logic               write;
        logic               read;
    } cmd_t;

    cmd_t              in_cmd;
    cmd_t              main_cmd;
    logic              in_vld, in_rdy, main_vld;
    logic              cap_ok, cmd_ok, out_rdy, drain;
    logic              rd_drain, rsp_ok;
    logic [PW-1:0]     pend_q, pend_d;
    logic              err_q, err_d;
    logic              rdv_q;
    logic [DWIDTH-1:0] rdata_q;

    // A combined read+write is carried as a read; the write half is dropped
    always_comb begin
        in_cmd       = '0;
        in_cmd.addr  = s_address;
        in_cmd.wdata = s_writedata;
        in_cmd.be    = s_byteenable;
        in_cmd.write = s_write & ~s_read;
        in_cmd.read  = s_read;
    end

    assign in_vld = s_read | s_write;

    avalon_mm_skid_buf #(.T(cmd_t)) u_cmd_buf (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .in_vld_i  (in_vld),
        .in_rdy_o  (in_rdy),
        .in_dat_i  (in_cmd),
        .out_vld_o (main_vld),
        .out_rdy_i (out_rdy),
        .out_dat_o (main_cmd)
    );

    assign cap_ok  = pend_q < PW'(MAX_PENDING);
    assign cmd_ok  = main_cmd.write | cap_ok;
    assign out_rdy = cmd_ok & ~m_waitrequest;
    assign drain   = main_vld & out_rdy;

    assign rd_drain = drain & main_cmd.read;
    assign rsp_ok   = m_readdatavalid & (pend_q != '0);

    always_comb begin
        pend_d = pend_q + PW'(rd_drain) - PW'(rsp_ok);
        err_d  = err_q
               | (in_vld & in_rdy & s_read & s_write)
               | (m_readdatavalid & (pend_q == '0));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q  <= '0;
            err_q   <= 1'b0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
            rdv_q  <= m_readdatavalid;
            if (m_readdatavalid) begin
                rdata_q <= m_readdata;
            end
        end
    end

    assign s_waitrequest   = ~in_rdy;
    assign s_readdata      = rdata_q;
    assign s_readdatavalid = rdv_q;
    assign m_address       = main_cmd.addr;
    assign m_writedata     = main_cmd.wdata;
    assign m_byteenable    = main_cmd.be;
    assign m_write         = main_vld & main_cmd.write;
    assign m_read          = main_vld & main_cmd.read & cap_ok;
    assign pending_o       = pend_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_avalon_mm_pipe_bridge.sv
// Scoreboarded bench for avalon_mm_pipe_bridge: directed corner cases, then randomized traffic
// against a queue-based model of command order, outstanding reads and response data.
module tb_avalon_mm_pipe_bridge;

    localparam int MAXP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  s_address;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_read;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic [1:0]  m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic [2:0]  pending_o;
    logic        err_o;

    typedef struct {
        logic [1:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        wr;
        logic        rd;
    } cmd_s;

    cmd_s        exp_cmd_q[$];
    logic [31:0] exp_rsp_q[$];
    bit          slave_rd_q[$];
    int          model_pend = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    avalon_mm_pipe_bridge #(.DWIDTH(32), .AWIDTH(2), .MAX_PENDING(MAXP)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .s_address       (s_address),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_read          (s_read),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .m_address       (m_address),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .pending_o       (pending_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic rd, input logic wr, input logic [1:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        cmd_s e;
        e.a  = a;
        e.d  = d;
        e.be = be;
        e.rd = rd;
        e.wr = wr & ~rd;
        exp_cmd_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance
    task automatic issue(input logic rd, input logic wr, input logic [1:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        bit done = 0;
        s_read       = rd;
        s_write      = wr;
        s_address    = a;
        s_writedata  = d;
        s_byteenable = be;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (!s_waitrequest) begin
                push_cmd(rd, wr, a, d, be);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        s_read  = 1'b0;
        s_write = 1'b0;
        chk("issue_accept_timeout", 64'(done), 64'(1));
    endtask

    task automatic respond(input logic [31:0] d);
        m_readdatavalid = 1'b1;
        m_readdata      = d;
        exp_rsp_q.push_back(d);
        if (slave_rd_q.size() > 0) void'(slave_rd_q.pop_front());
        @(posedge clk);
        #1;
        m_readdatavalid = 1'b0;
    endtask

    task automatic flush_reads();
        for (int k = 0; k < 40; k++) begin
            if (slave_rd_q.size() > 0) respond($urandom);
            else idle(1);
        end
    endtask

    // Monitor: sampled on the falling edge, describing what the next rising edge commits
    always @(negedge clk) begin
        cmd_s e;
        int   old;
        if (!rst_n) begin
            model_pend = 0;
        end else begin
            chk("pending", 64'(pending_o), 64'(model_pend));
            chk("read_cap", 64'(m_read && (model_pend >= MAXP)), 64'(0));
            old = model_pend;
            if ((m_read || m_write) && !m_waitrequest) begin
                if (exp_cmd_q.size() == 0) begin
                    chk("unexpected_cmd", 64'(1), 64'(0));
                end else begin
                    e = exp_cmd_q.pop_front();
                    chk("cmd_addr",  64'(m_address),    64'(e.a));
                    chk("cmd_wdata", 64'(m_writedata),  64'(e.d));
                    chk("cmd_be",    64'(m_byteenable), 64'(e.be));
                    chk("cmd_write", 64'(m_write),      64'(e.wr));
                    chk("cmd_read",  64'(m_read),       64'(e.rd));
                end
                if (m_read) begin
                    slave_rd_q.push_back(1'b1);
                    model_pend = model_pend + 1;
                end
            end
            if (m_readdatavalid && old > 0) model_pend = model_pend - 1;
            if (s_readdatavalid) begin
                if (exp_rsp_q.size() == 0) chk("unexpected_rsp", 64'(1), 64'(0));
                else chk("rsp_data", 64'(s_readdata), 64'(exp_rsp_q.pop_front()));
            end
        end
    end

    initial begin
        bit          act;
        int          k;
        logic [31:0] d;
        s_address = '0; s_write = 0; s_writedata = '0; s_byteenable = '0; s_read = 0;
        m_waitrequest = 0; m_readdata = '0; m_readdatavalid = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_waitrequest", 64'(s_waitrequest), 64'(0));
        chk("rst_m_read",        64'(m_read),        64'(0));
        chk("rst_m_write",       64'(m_write),       64'(0));
        chk("rst_m_address",     64'(m_address),     64'(0));
        chk("rst_m_writedata",   64'(m_writedata),   64'(0));
        chk("rst_m_byteenable",  64'(m_byteenable),  64'(0));
        chk("rst_rdv",           64'(s_readdatavalid), 64'(0));
        chk("rst_readdata",      64'(s_readdata),    64'(0));
        chk("rst_err",           64'(err_o),         64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back writes appear downstream one cycle after acceptance
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 1'b1, 2'(i % 4), 32'h1000_0000 + 32'(i), 4'hF);
            chk("b2b_m_write",   64'(m_write),       64'(1));
            chk("b2b_m_address", 64'(m_address),     64'(i % 4));
            chk("b2b_m_wdata",   64'(m_writedata),   64'(32'h1000_0000 + 32'(i)));
            chk("b2b_s_wait",    64'(s_waitrequest), 64'(0));
        end
        idle(3);

        // Downstream stall for 5 cycles: fields stable, second command fills the skid
        m_waitrequest = 1'b1;
        issue(1'b0, 1'b1, 2'd1, 32'hA5A5_0001, 4'h3);
        chk("stall_m_wdata", 64'(m_writedata), 64'(32'hA5A5_0001));
        issue(1'b0, 1'b1, 2'd2, 32'hA5A5_0002, 4'hC);
        chk("stall_s_wait",  64'(s_waitrequest), 64'(1));
        chk("stall_m_wdata", 64'(m_writedata),   64'(32'hA5A5_0001));
        for (int c = 0; c < 3; c++) begin
            idle(1);
            chk("stall_hold_addr",  64'(m_address),   64'(1));
            chk("stall_hold_wdata", 64'(m_writedata), 64'(32'hA5A5_0001));
            chk("stall_hold_write", 64'(m_write),     64'(1));
        end
        idle(1);
        m_waitrequest = 1'b0;
        idle(1);
        chk("unstall_m_wdata", 64'(m_writedata),   64'(32'hA5A5_0002));
        chk("unstall_s_wait",  64'(s_waitrequest), 64'(0));
        idle(2);

        // Read cap: six reads, no responses
        for (int i = 0; i < 6; i++) issue(1'b1, 1'b0, 2'(i % 4), 32'h0, 4'hF);
        chk("cap_pending", 64'(pending_o),     64'(4));
        chk("cap_m_read",  64'(m_read),        64'(0));
        chk("cap_s_wait",  64'(s_waitrequest), 64'(1));
        respond(32'hDEAD_BEEF);
        chk("cap_rsp_pending", 64'(pending_o),       64'(3));
        chk("cap_rsp_rdv",     64'(s_readdatavalid), 64'(1));
        chk("cap_rsp_data",    64'(s_readdata),      64'(32'hDEAD_BEEF));
        chk("cap_rsp_m_read",  64'(m_read),          64'(1));
        idle(1);
        chk("cap_after_pending", 64'(pending_o),       64'(4));
        chk("cap_after_rdv",     64'(s_readdatavalid), 64'(0));
        chk("cap_hold_data",     64'(s_readdata),      64'(32'hDEAD_BEEF));
        chk("cap_after_s_wait",  64'(s_waitrequest),   64'(0));
        flush_reads();
        chk("flush_pending", 64'(pending_o), 64'(0));

        // Response and read drain in the same cycle at pending 2
        issue(1'b1, 1'b0, 2'd0, 32'h0, 4'hF);
        issue(1'b1, 1'b0, 2'd1, 32'h0, 4'hF);
        issue(1'b1, 1'b0, 2'd2, 32'h0, 4'hF);
        chk("same_pre_pending", 64'(pending_o), 64'(2));
        chk("same_pre_m_read",  64'(m_read),    64'(1));
        respond(32'h0BAD_F00D);
        chk("same_post_pending", 64'(pending_o), 64'(2));
        flush_reads();

        // Spurious response at pending 0
        chk("spur_pre_err", 64'(err_o), 64'(0));
        respond(32'h1234_5678);
        chk("spur_err",     64'(err_o),           64'(1));
        chk("spur_rdv",     64'(s_readdatavalid), 64'(1));
        chk("spur_data",    64'(s_readdata),      64'(32'h1234_5678));
        chk("spur_pending", 64'(pending_o),       64'(0));
        idle(2);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        chk("err_cleared", 64'(err_o), 64'(0));

        // Read and write together: carried as a read, flagged
        issue(1'b1, 1'b1, 2'd3, 32'hFFFF_0000, 4'b0101);
        chk("rw_m_read",  64'(m_read),       64'(1));
        chk("rw_m_write", 64'(m_write),      64'(0));
        chk("rw_be",      64'(m_byteenable), 64'(4'b0101));
        chk("rw_addr",    64'(m_address),    64'(3));
        chk("rw_err",     64'(err_o),        64'(1));
        flush_reads();

        // Reset with commands queued
        m_waitrequest = 1'b1;
        issue(1'b0, 1'b1, 2'd1, 32'h5555_0001, 4'hF);
        issue(1'b0, 1'b1, 2'd2, 32'h5555_0002, 4'hF);
        chk("mq_s_wait", 64'(s_waitrequest), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mq_rst_m_write", 64'(m_write),         64'(0));
        chk("mq_rst_m_wdata", 64'(m_writedata),     64'(0));
        chk("mq_rst_s_wait",  64'(s_waitrequest),   64'(0));
        chk("mq_rst_pending", 64'(pending_o),       64'(0));
        chk("mq_rst_err",     64'(err_o),           64'(0));
        chk("mq_rst_rdata",   64'(s_readdata),      64'(0));
        exp_cmd_q.delete();
        exp_rsp_q.delete();
        slave_rd_q.delete();
        idle(2);
        rst_n = 1'b1;
        m_waitrequest = 1'b0;
        idle(3);
        chk("mq_post_m_write", 64'(m_write), 64'(0));

        // Randomized traffic with a random-latency slave
        act = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            m_waitrequest = ($urandom_range(0, 3) == 0);
            if (slave_rd_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                d = $urandom;
                m_readdatavalid = 1'b1;
                m_readdata      = d;
                exp_rsp_q.push_back(d);
                void'(slave_rd_q.pop_front());
            end else begin
                m_readdatavalid = 1'b0;
            end
            if (!act) begin
                if ($urandom_range(0, 3) != 0) begin
                    k            = $urandom_range(0, 7);
                    s_read       = (k < 4);
                    s_write      = (k == 0) || (k >= 4);
                    s_address    = 2'($urandom_range(0, 3));
                    s_writedata  = $urandom;
                    s_byteenable = 4'($urandom_range(0, 15));
                    act          = 1;
                end else begin
                    s_read  = 1'b0;
                    s_write = 1'b0;
                end
            end
            @(negedge clk);
            if (act && !s_waitrequest) begin
                push_cmd(s_read, s_write, s_address, s_writedata, s_byteenable);
                act = 0;
            end
            @(posedge clk);
            #1;
        end
        s_read = 1'b0;
        s_write = 1'b0;
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b0;
        flush_reads();
        idle(3);
        chk("end_cmd_q_empty", 64'(exp_cmd_q.size()), 64'(0));
        chk("end_rsp_q_empty", 64'(exp_rsp_q.size()), 64'(0));
        chk("end_pending",     64'(pending_o),        64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
